// File: rtl/activation_pkg.sv
// Shared activation-stage definitions: PWL sigmoid knots, range limits, logit FSM states.
// Consumers: sigmoid_pwl, logit_search (optional LOGIT_ROUND_NEAREST_EN build).
package activation_pkg;

  localparam logic signed [7:0] KNOT_X [0:7] = '{8'h80, 8'hA0, 8'hC0, 8'hE0,
                                                 8'h00, 8'h20, 8'h40, 8'h60};
  // Entry 8 is the virtual knot at x = 128 that closes the last segment.
  localparam logic [7:0] KNOT_Y [0:8] = '{8'd4, 8'd30, 8'd62, 8'd100, 8'd128,
                                          8'd156, 8'd193, 8'd225, 8'd252};

  localparam logic [7:0]        SIG_HALF = 8'd128;
  localparam logic [7:0]        SIG_MIN  = 8'd4;
  localparam logic [7:0]        SIG_MAX  = 8'd251;
  localparam logic signed [7:0] X_MIN    = 8'h80;
  localparam logic signed [7:0] X_MAX    = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Offset code u (x + 128) to signed Q3.5, with clamping on out-of-range probabilities.
  function automatic logic [7:0] logit_code(input logic [7:0] u, input logic lo, input logic hi);
    if (lo) return X_MIN;
    if (hi) return X_MAX;
    return u ^ 8'h80;
  endfunction

endpackage

// File: rtl/sigmoid_pwl.sv
// Combinational piecewise-linear sigmoid: signed Q3.5 x -> unsigned probability code y.
module sigmoid_pwl
  import activation_pkg::*;
(
  input  logic signed [7:0] x,
  output logic        [7:0] y
);

  logic [3:0]  seg;
  logic [4:0]  off;
  logic [7:0]  dy;
  logic [10:0] prod;

  always_comb begin
    // Segment index is the top three bits of the offset code x + 128.
    seg  = {1'b0, x[7:5] ^ 3'b100};
    off  = 5'(x - KNOT_X[seg[2:0]]);
    dy   = KNOT_Y[seg + 4'd1] - KNOT_Y[seg];
    prod = {3'b000, dy} * {6'b000000, off};
    y    = KNOT_Y[seg] + 8'(prod >> 5);
  end

endmodule

// File: rtl/logit_search.sv
// Logit unit: successive-approximation inverse of sigmoid_pwl, valid/ready on both sides.
// Optional LOGIT_ROUND_NEAREST_EN adds a one-cycle round-to-nearest step before DONE.
module logit_search
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat
);

  if (DATA_WIDTH != 8 || FRAC_BITS != 5) begin : g_bad_cfg
    $error("logit_search supports only DATA_WIDTH=8, FRAC_BITS=5");
  end

  state_e      state_q, state_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  u_q, u_d;
  logic [2:0]  b_q, b_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sat_q, out_sat_d;
`ifdef LOGIT_ROUND_NEAREST_EN
  logic [7:0]  slo_q, slo_d;
`endif

  logic [7:0]        trial;
  logic signed [7:0] sig_x;
  logic [7:0]        sig_y;
  logic              sat_lo, sat_hi;

  sigmoid_pwl u_sig (
    .x (sig_x),
    .y (sig_y)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    u_d         = u_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
`ifdef LOGIT_ROUND_NEAREST_EN
    slo_d       = slo_q;
`endif
    trial  = u_q | (8'd1 << b_q);
    sig_x  = trial ^ 8'h80;
    sat_lo = y_q < SIG_MIN;
    sat_hi = y_q > SIG_MAX;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          y_d     = in_data;
          u_d     = '0;
          b_d     = 3'd7;
`ifdef LOGIT_ROUND_NEAREST_EN
          slo_d   = SIG_MIN;
`endif
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (sig_y <= y_q) begin
          u_d = trial;
`ifdef LOGIT_ROUND_NEAREST_EN
          // Track sig(u) so rounding needs only one extra sigmoid evaluation.
          slo_d = sig_y;
`endif
        end
        b_d = b_q - 3'd1;
        if (b_q == 3'd0) begin
`ifdef LOGIT_ROUND_NEAREST_EN
          state_d = ST_ROUND;
`else
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_sat_d   = sat_lo | sat_hi;
          out_data_d  = logit_code(u_d, sat_lo, sat_hi);
`endif
        end
      end
`ifdef LOGIT_ROUND_NEAREST_EN
      ST_ROUND: begin
        sig_x = (u_q + 8'd1) ^ 8'h80;
        if (u_q != 8'hFF && !(sat_lo || sat_hi) && (sig_y - y_q) < (y_q - slo_q)) begin
          u_d = u_q + 8'd1;
        end
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        out_sat_d   = sat_lo | sat_hi;
        out_data_d  = logit_code(u_d, sat_lo, sat_hi);
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      u_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
`ifdef LOGIT_ROUND_NEAREST_EN
      slo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      u_q         <= u_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
`ifdef LOGIT_ROUND_NEAREST_EN
      slo_q       <= slo_d;
`endif
    end
  end

endmodule

// File: tb/tb_logit_search.sv
// Self-checking bench for logit_search against a brute-force inverse-sigmoid reference model.
module tb_logit_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sat;

  int tests = 0;
  int fails = 0;

`ifdef LOGIT_ROUND_NEAREST_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  int ky [0:8] = '{4, 30, 62, 100, 128, 156, 193, 225, 252};

  always #5 clk = ~clk;

  logit_search #(.DATA_WIDTH(8), .FRAC_BITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  function automatic int sig_ref(input int x);
    int k;
    int x0;
    k  = (x + 128) / 32;
    x0 = -128 + 32 * k;
    return ky[k] + ((ky[k+1] - ky[k]) * (x - x0)) / 32;
  endfunction

  function automatic int logit_ref(input int y);
    int x;
    x = -128;
    for (int c = -128; c <= 127; c++) if (sig_ref(c) <= y) x = c;
`ifdef LOGIT_ROUND_NEAREST_EN
    if (y >= 4 && y <= 251 && x < 127 && (sig_ref(x + 1) - y) < (y - sig_ref(x))) x = x + 1;
`endif
    return x;
  endfunction

  function automatic bit sat_ref(input int y);
    return (y < 4) || (y > 251);
  endfunction

  task automatic run_one(input logic [7:0] y, input int hold,
                         output logic [7:0] data, output logic sat, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    data = out_data;
    sat  = out_sat;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++;
    if (out_data !== 8'd0) begin fails++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    tests++;
    if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_half;
    logic [7:0] d;
    logic s;
    int lat;
    run_one(8'd128, 0, d, s, lat);
    tests++;
    if ($signed(d) !== 8'sd1) begin fails++; $display("FAIL half_data got=%0d exp=1", $signed(d)); end
    tests++;
    if (s !== 1'b0) begin fails++; $display("FAIL half_sat got=%b exp=0", s); end
    tests++;
    if (lat !== LAT) begin fails++; $display("FAIL half_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_sweep;
    logic [7:0] d;
    logic s;
    int lat;
    for (int y = 0; y < 256; y++) begin
      run_one(8'(y), int'($urandom_range(0, 2)), d, s, lat);
      tests++;
      if (int'($signed(d)) !== logit_ref(y) || s !== sat_ref(y) || lat !== LAT)
        begin
          fails++;
          $display("FAIL sweep y=%0d got x=%0d sat=%b lat=%0d exp x=%0d sat=%b lat=%0d",
                   y, $signed(d), s, lat, logit_ref(y), sat_ref(y), LAT);
        end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] y;
    logic [7:0] d0;
    int lat;
    y = 8'($urandom_range(160, 250));
    in_valid = 1'b1;
    in_data  = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d0 = out_data;
    tests++;
    if (int'($signed(d0)) !== logit_ref(int'(y)) || lat !== LAT) begin
      fails++;
      $display("FAIL bp_result y=%0d got x=%0d lat=%0d exp x=%0d lat=%0d",
               y, $signed(d0), lat, logit_ref(int'(y)), LAT);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%0d rdy=%b exp v=1 d=%0d rdy=0",
                 i, out_valid, out_data, in_ready, d0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic s;
    int lat;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_search got v=%b d=%0d rdy=%b exp v=0 d=0 rdy=0", out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    run_one(8'd128, 0, d, s, lat);
    tests++;
    if ($signed(d) !== 8'sd1 || s !== 1'b0) begin
      fails++;
      $display("FAIL rst_recover got x=%0d sat=%b exp x=1 sat=0", $signed(d), s);
    end
    // Abort from DONE while holding a nonzero result.
    in_valid = 1'b1;
    in_data  = 8'($urandom_range(170, 250));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || lat !== LAT) begin
      fails++;
      $display("FAIL rst_done got v=%b d=%0d lat=%0d exp v=0 d=0 lat=%0d", out_valid, out_data, lat, LAT);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int exp_q[$];
    int hs_cyc[$];
    int pushed;
    int got;
    int cyc;
    int e;
    pushed = 0;
    got = 0;
    cyc = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < 6 && cyc < 200) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 999;
        tests++;
        if (int'($signed(out_data)) !== e) begin
          fails++;
          $display("FAIL b2b_result n=%0d got x=%0d exp x=%0d", got, $signed(out_data), e);
        end
        got++;
      end
      in_data = 8'($urandom);
      if (in_ready && pushed < 6) begin
        exp_q.push_back(logit_ref(int'(in_data)));
        hs_cyc.push_back(cyc);
        pushed++;
        if (pushed == 6) in_valid = 1'b1;
      end else if (pushed == 6) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (got !== 6) begin fails++; $display("FAIL b2b_count got=%0d exp=6", got); end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      tests++;
      if (hs_cyc[i] - hs_cyc[i-1] !== LAT + 1) begin
        fails++;
        $display("FAIL b2b_spacing n=%0d got=%0d exp=%0d", i, hs_cyc[i] - hs_cyc[i-1], LAT + 1);
      end
    end
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_half();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
